// File: rtl/onehot_key_capture.sv
// Debounced one-hot key capture with a ready/valid handoff to an 8-to-3 encoder stage.
// Optional build macro PRIORITY_RESOLVE_EN: multi-hot patterns resolve to their lowest set bit.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a stable non-zero pattern
// HOLD     | onehot/valid presented, waiting for ready
// WAIT_REL | code consumed or rejected, waiting for a stable all-zero release
module onehot_key_capture #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       ready,
  output logic [7:0] onehot,
  output logic       valid,
  output logic       err
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;

  state_t           state_q, state_d;
  logic [7:0]       sync_meta, sync, sync_prev;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             stable, is_zero, is_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 8'h00;
      sync      <= 8'h00;
      sync_prev <= 8'h00;
      cnt_q     <= '0;
    end else begin
      sync_meta <= key_in;
      sync      <= sync_meta;
      sync_prev <= sync;
      if (sync != sync_prev)
        cnt_q <= '0;
      else if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A saturated count only counts as stable if sync did not just change;
  // otherwise a fresh edge would be accepted before the counter clears.
  assign stable    = (cnt_q == CNT_MAX) && (sync == sync_prev);
  assign is_zero   = (sync == 8'h00);
  assign is_onehot = !is_zero && ((sync & (sync - 8'd1)) == 8'h00);

`ifdef PRIORITY_RESOLVE_EN
  logic [7:0] lowest;
  assign lowest = sync & (~sync + 8'd1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      onehot_q <= 8'h00;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (stable && !is_zero) begin
          if (is_onehot) begin
            onehot_d = sync;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end else begin
`ifdef PRIORITY_RESOLVE_EN
            onehot_d = lowest;
            valid_d  = 1'b1;
            state_d  = HOLD;
`else
            err_d    = 1'b1;
            state_d  = WAIT_REL;
`endif
          end
        end
      end
      HOLD: begin
        valid_d = 1'b1;
        if (ready) begin
          valid_d = 1'b0;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        valid_d = 1'b0;
        if (stable && is_zero)
          state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign onehot = onehot_q;
  assign valid  = valid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_onehot_key_capture.sv
// Directed bench for onehot_key_capture with DEB_CYCLES=4.
// Honours PRIORITY_RESOLVE_EN for the multi-hot case.
module tb_onehot_key_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_in;
  logic       ready;
  logic [7:0] onehot;
  logic       valid;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid, n_err;

  onehot_key_capture #(.DEB_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .ready  (ready),
    .onehot (onehot),
    .valid  (valid),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle_idle();
    key_in = 8'h00;
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    rst    = 1'b1;
    key_in = 8'h00;
    ready  = 1'b0;
    tick();
    tick();
    check("rst_onehot", onehot, 8'h00);
    check("rst_valid", {7'd0, valid}, 8'h00);
    check("rst_err", {7'd0, err}, 8'h00);
    rst = 1'b0;
    settle_idle();

    // clean press, ready held high: one-cycle valid at edge 7
    key_in = 8'h04;
    ready  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("press_early_valid", {7'd0, valid}, 8'h00);
    end
    tick();
    check("press_valid_e7", {7'd0, valid}, 8'h01);
    check("press_onehot", onehot, 8'h04);
    tick();
    check("press_valid_pulse", {7'd0, valid}, 8'h00);
    settle_idle();

    // after release the block is back in IDLE and captures a new key
    key_in = 8'h08;
    for (int i = 0; i < 7; i++) tick();
    tick();
    check("repress_valid", {7'd0, valid}, 8'h01);
    check("repress_onehot", onehot, 8'h08);
    settle_idle();

    // bounce: toggling every 2 cycles never becomes stable
    n_valid = 0;
    n_err   = 0;
    for (int i = 0; i < 20; i++) begin
      key_in = ((i >> 1) & 1) != 0 ? 8'h00 : 8'h10;
      tick();
      n_valid += int'(valid);
      n_err   += int'(err);
    end
    check("bounce_no_valid", 8'(n_valid), 8'd0);
    check("bounce_no_err", 8'(n_err), 8'd0);
    key_in  = 8'h10;
    n_valid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (valid) begin
        n_valid++;
        check("bounce_onehot", onehot, 8'h10);
      end
    end
    check("bounce_one_valid", 8'(n_valid), 8'd1);
    settle_idle();

    // multi-hot pattern
    key_in  = 8'h81;
    n_valid = 0;
    n_err   = 0;
    for (int i = 0; i < 7; i++) tick();
    tick();
`ifdef PRIORITY_RESOLVE_EN
    check("multi_valid_e7", {7'd0, valid}, 8'h01);
    check("multi_onehot", onehot, 8'h01);
    check("multi_err", {7'd0, err}, 8'h00);
`else
    check("multi_err_e7", {7'd0, err}, 8'h01);
    check("multi_valid", {7'd0, valid}, 8'h00);
`endif
    for (int i = 0; i < 20; i++) begin
      tick();
      n_valid += int'(valid);
      n_err   += int'(err);
    end
    check("multi_no_more_err", 8'(n_err), 8'd0);
    check("multi_no_more_valid", 8'(n_valid), 8'd0);
    settle_idle();

    // hold with ready low while key changes
    ready  = 1'b0;
    key_in = 8'h02;
    for (int i = 0; i < 8; i++) tick();
    check("hold_valid", {7'd0, valid}, 8'h01);
    check("hold_onehot", onehot, 8'h02);
    key_in  = 8'h40;
    n_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_valid += int'(valid);
      check("hold_onehot_const", onehot, 8'h02);
    end
    check("hold_valid_count", 8'(n_valid), 8'd10);
    ready = 1'b1;
    tick();
    check("hold_valid_fall", {7'd0, valid}, 8'h00);
    n_valid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_valid += int'(valid);
    end
    check("wait_rel_no_capture", 8'(n_valid), 8'd0);
    settle_idle();
    key_in = 8'h40;
    for (int i = 0; i < 8; i++) tick();
    check("after_rel_valid", {7'd0, valid}, 8'h01);
    check("after_rel_onehot", onehot, 8'h40);
    settle_idle();

    // reset during HOLD, with ready high in the reset cycle
    ready  = 1'b0;
    key_in = 8'h20;
    for (int i = 0; i < 8; i++) tick();
    check("pre_rst_valid", {7'd0, valid}, 8'h01);
    tick();
    rst   = 1'b1;
    ready = 1'b1;
    tick();
    check("mid_rst_valid", {7'd0, valid}, 8'h00);
    check("mid_rst_onehot", onehot, 8'h00);
    rst   = 1'b0;
    ready = 1'b0;
    n_valid = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_valid += int'(valid);
    end
    check("post_rst_early", 8'(n_valid), 8'd0);
    tick();
    check("post_rst_recapture", {7'd0, valid}, 8'h01);
    check("post_rst_onehot", onehot, 8'h20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_key_capture.md
ONEHOT_KEY_CAPTURE -- requirements
Module: onehot_key_capture

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 16: consecutive stable cycles required before a pattern is accepted (range 2..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port key_in, input, 8 bits: raw asynchronous switch/key lines, active-high.
REQ-005 The block SHALL have port ready, input, 1 bit: the downstream 8-to-3 encoder stage accepts onehot.
REQ-006 The block SHALL have port onehot, output, 8 bits: registered debounced one-hot code, exactly one bit set while valid=1.
REQ-007 The block SHALL have port valid, output, 1 bit: onehot holds an accepted code.
REQ-008 The block SHALL have port err, output, 1 bit: one-cycle pulse on a rejected multi-hot pattern.

Function
REQ-009 The block SHALL pass key_in through a 2-flop synchronizer (sync) before any other use.
REQ-010 The block SHALL keep a debounce counter that clears whenever sync differs from its previous-cycle value, increments otherwise, and saturates at DEB_CYCLES; stable = (counter == DEB_CYCLES).
REQ-011 The block SHALL implement states IDLE, HOLD and WAIT_REL, with IDLE as the reset state.
REQ-012 In IDLE with stable=1 and sync one-hot, the block SHALL load onehot<=sync, set valid=1 and go to HOLD.
REQ-013 In IDLE with stable=1 and sync having 2+ bits set, the block SHALL pulse err for exactly one cycle, leave valid=0 and onehot unchanged, and go to WAIT_REL.
REQ-014 In IDLE with stable=1 and sync all-zero, the block SHALL remain in IDLE.
REQ-015 In HOLD, the block SHALL keep valid=1 and onehot constant regardless of key_in until a cycle with ready=1, then deassert valid on the next edge and go to WAIT_REL.
REQ-016 Holding ready=1 permanently SHALL give a valid pulse of exactly one cycle.
REQ-017 In WAIT_REL, the block SHALL go to IDLE only when stable=1 and sync is all-zero; new presses SHALL be ignored until then, so one press yields at most one code.
REQ-018 With key_in settling to a new value at edge 0 and held, valid (or err) SHALL rise at edge DEB_CYCLES+3.
REQ-019 A bounce (sync change) before stable SHALL restart the DEB_CYCLES count, with no output.
REQ-020 The counter width SHALL be $clog2(DEB_CYCLES+1) bits, with no wrap-around.

Reset
REQ-021 When rst=1 at a clock edge, the block SHALL set state IDLE, onehot=8'h00, valid=0, err=0, the synchronizer flops to 0 and the counter to 0, including mid-HOLD, where the pending code is discarded.
REQ-022 When rst=1 and ready=1 occur in the same cycle, reset SHALL take priority.

Configuration
REQ-023 With macro PRIORITY_RESOLVE_EN defined, a stable multi-hot pattern in IDLE SHALL be resolved to its lowest set bit, loaded as onehot with valid=1 and the state going to HOLD, and err SHALL be held constant 0.
REQ-024 With PRIORITY_RESOLVE_EN undefined, the block SHALL behave as REQ-013.

Verification (DEB_CYCLES=4)
REQ-025 The bench SHALL check: rst, then key_in=8'h04 held clean, ready=1 -> valid=1 at edge 7 with onehot=8'h04 for one cycle; release key -> state returns to IDLE.
REQ-026 The bench SHALL check: key_in toggles 8'h00/8'h10 every 2 cycles for 20 cycles, then 8'h10 held -> no valid during the toggling, then exactly one valid with onehot=8'h10.
REQ-027 The bench SHALL check: key_in=8'h81 held -> err pulses once, valid stays 0, and no further err until release (macro undefined); with PRIORITY_RESOLVE_EN defined -> onehot=8'h01 and valid=1.
REQ-028 The bench SHALL check: key_in=8'h02 with ready=0 for 10 cycles while key_in changes to 8'h40 -> valid stays 1 and onehot stays 8'h02; ready=1 -> valid falls on the next edge, and 8'h40 is not captured until a release is seen.
REQ-029 The bench SHALL check: rst asserted for one cycle during HOLD -> next edge gives valid=0 and onehot=8'h00, and the held key is re-captured DEB_CYCLES+3 edges after rst drops.
